// File: rtl/axis_pkt_source.sv
// rtl/axis_pkt_source.sv - byte FIFO packetizer driving an AXI-Stream master with periodic or flushed tlast
// tlast is stored alongside each byte at write time, so the head beat stays stable under backpressure.
module axis_pkt_source #(
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   wr_flush,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [15:0]            pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] BEAT_MAX = 8'(PKT_LEN - 1);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    wr_beat_q, wr_beat_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic          overflow_q, overflow_d;
  logic          wr_acc, rd_xfer, wr_last;
  logic [8:0]    head;

  always_comb begin
    head        = mem_q[rd_ptr_q];
    full        = (level_q == LW'(DEPTH));
    m_tvalid    = (level_q != '0);
    wr_acc      = wr_en & ~full;
    rd_xfer     = m_tvalid & m_tready;
    wr_last     = (wr_beat_q == BEAT_MAX) | wr_flush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wr_beat_d   = wr_beat_q;
    pkt_count_d = pkt_count_q;
    overflow_d  = overflow_q;

    // Dropped writes leave the beat counter alone so packet boundaries are not shifted.
    if (wr_acc) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      wr_beat_d = wr_last ? 8'd0 : wr_beat_q + 8'd1;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_xfer) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (head[8]) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end

    case ({wr_acc, rd_xfer})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_beat_q   <= '0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_beat_q   <= wr_beat_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && wr_acc) begin
      mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end
  end

  assign level     = level_q;
  assign overflow  = overflow_q;
  assign pkt_count = pkt_count_q;
  assign m_tdata   = m_tvalid ? head[7:0] : 8'd0;
  assign m_tlast   = m_tvalid ? head[8] : 1'b0;

endmodule

// File: tb/tb_axis_pkt_source.sv
// tb/tb_axis_pkt_source.sv - directed bench for axis_pkt_source (DEPTH=16, PKT_LEN=4)
module tb_axis_pkt_source;
  logic        aclk;
  logic        areset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_flush;
  logic        full;
  logic        overflow;
  logic [4:0]  level;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] pkt_count;

  int vectors = 0;
  int miscompares = 0;

  axis_pkt_source #(.DEPTH(16), .PKT_LEN(4)) dut (
    .aclk(aclk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_flush(wr_flush), .full(full), .overflow(overflow), .level(level),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .pkt_count(pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic f);
    wr_en = 1'b1; wr_data = d; wr_flush = f;
    tick();
    wr_en = 1'b0; wr_flush = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_tdata"}, 32'(m_tdata), 32'(d));
    chk({tag, "_tlast"}, 32'(m_tlast), 32'(l));
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
  endtask

  initial begin
    areset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_flush = 1'b0; m_tready = 1'b0;
    tick(); tick();
    areset = 1'b0;
    tick();
    chk_reset_state("reset");

    // Basic packetization with tready held high.
    m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + k);
      if (k == 0) chk("basic_no_bypass", 32'(m_tvalid), 32'd0);
      tick();
      chk("basic_tdata", 32'(m_tdata), 32'(8'h10 + k));
      chk("basic_tlast", 32'(m_tlast), 32'((k % 4) == 3));
      chk("basic_level", 32'(level), 32'd1);
    end
    wr_en = 1'b0;
    tick();
    chk("basic_empty", 32'(m_tvalid), 32'd0);
    chk("basic_tdata_gated", 32'(m_tdata), 32'd0);
    chk("basic_pkt_count", 32'(pkt_count), 32'd2);
    m_tready = 1'b0;

    // Backpressure: head must hold while tready is low.
    for (int k = 0; k < 4; k++) put(8'(8'hA0 + k), 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_tdata", 32'(m_tdata), 32'hA0);
      chk("bp_tlast", 32'(m_tlast), 32'd0);
      chk("bp_level", 32'(level), 32'd4);
      tick();
    end
    for (int k = 0; k < 4; k++) pop("bp_drain", 8'(8'hA0 + k), k == 3);
    chk("bp_pkt_count", 32'(pkt_count), 32'd3);

    // Flush: early tlast, and wr_flush without wr_en is ignored.
    put(8'h01, 1'b0);
    put(8'h02, 1'b1);
    wr_flush = 1'b1; tick(); wr_flush = 1'b0;
    chk("flush_idle_level", 32'(level), 32'd2);
    for (int k = 3; k <= 6; k++) put(8'(k), 1'b0);
    chk("flush_level", 32'(level), 32'd6);
    pop("flush", 8'h01, 1'b0);
    pop("flush", 8'h02, 1'b1);
    pop("flush", 8'h03, 1'b0);
    pop("flush", 8'h04, 1'b0);
    pop("flush", 8'h05, 1'b0);
    pop("flush", 8'h06, 1'b1);
    chk("flush_pkt_count", 32'(pkt_count), 32'd5);

    // Overflow: fill 16, drop the 17th.
    for (int k = 0; k < 17; k++) begin
      put(8'(8'h20 + k), 1'b0);
      if (k == 14) chk("ovf_not_full", 32'(full), 32'd0);
      if (k == 15) begin
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_level16", 32'(level), 32'd16);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_level_after_drop", 32'(level), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    pop("ovf_drain", 8'h20, 1'b0);
    chk("ovf_full_release", 32'(full), 32'd0);
    chk("ovf_level15", 32'(level), 32'd15);
    for (int k = 1; k < 16; k++) pop("ovf_drain", 8'(8'h20 + k), (k % 4) == 3);
    for (int k = 0; k < 4; k++) put(8'(8'h40 + k), 1'b0);
    for (int k = 0; k < 4; k++) pop("ovf_align", 8'(8'h40 + k), k == 3);
    chk("ovf_pkt_count", 32'(pkt_count), 32'd10);

    // Simultaneous read and write at level 8, then a dropped write during a read from full.
    for (int k = 0; k < 8; k++) put(8'(8'h50 + k), 1'b0);
    chk("sim_level8", 32'(level), 32'd8);
    m_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h58 + k);
      chk("sim_tdata", 32'(m_tdata), 32'(8'h50 + k));
      tick();
      chk("sim_level", 32'(level), 32'd8);
    end
    wr_en = 1'b0; m_tready = 1'b0;
    for (int k = 0; k < 8; k++) put(8'(8'h62 + k), 1'b0);
    chk("sim_full", 32'(full), 32'd1);
    m_tready = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    m_tready = 1'b0; wr_en = 1'b0;
    chk("sim_drop_level", 32'(level), 32'd15);
    chk("sim_drop_full", 32'(full), 32'd0);
    for (int k = 8'h5B; k <= 8'h69; k++) pop("sim_drain", 8'(k), ((k - 8'h50) % 4) == 3);
    chk("sim_pkt_count", 32'(pkt_count), 32'd16);
    put(8'h6A, 1'b0);
    put(8'h6B, 1'b0);
    pop("sim_tail", 8'h6A, 1'b0);
    pop("sim_tail", 8'h6B, 1'b1);

    // Reset mid-packet.
    put(8'h70, 1'b0);
    put(8'h71, 1'b0);
    pop("rst_pre", 8'h70, 1'b0);
    chk("rst_pre_level", 32'(level), 32'd1);
    areset = 1'b1; tick(); areset = 1'b0;
    chk_reset_state("rst_mid");
    for (int k = 0; k < 4; k++) put(8'(8'h80 + k), 1'b0);
    for (int k = 0; k < 4; k++) pop("rst_post", 8'(8'h80 + k), k == 3);
    chk("rst_post_pkt_count", 32'(pkt_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
